// File: rtl/hbm_mem_model_pkg.sv
// rtl/hbm_mem_model_pkg.sv - shared constants, state types and helpers for the HBM AXI memory model
package hbm_mem_model_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [1:0] resp_of(input logic dec, input logic slv);
        return dec ? DECERR : (slv ? SLVERR : OKAY);
    endfunction

endpackage

// File: rtl/hbm_mem_model_ram.sv
// rtl/hbm_mem_model_ram.sv - DEPTH x DATA_W storage with byte-enable write and asynchronous read
module hbm_mem_model_ram #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hbm_axi_mem_model.sv
// rtl/hbm_axi_mem_model.sv - AXI4 slave memory model for one HBM pseudo-channel; HBM_MEM_STALL_EN adds LFSR backpressure
module hbm_axi_mem_model
    import hbm_mem_model_pkg::*;
#(
    parameter int          DATA_W       = 256,
    parameter int          ADDR_W       = 48,
    parameter int          DEPTH        = 4096,
    parameter int          ID_W         = 1,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input  logic                s_aclk,
    input  logic                s_areset,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int              BYTES     = DATA_W / 8;
    localparam int              SIZE      = $clog2(BYTES);
    localparam int              RAM_AW    = $clog2(DEPTH);
    localparam logic [2:0]      SIZE_CODE = 3'(SIZE);
    localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    logic w_stall;

`ifdef HBM_MEM_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge s_aclk) begin
        if (s_areset) r_lfsr <= STALL_SEED;
        else          r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // ---------------- write channel ----------------
    wstate_t             r_wstate, w_wstate_nxt;
    logic [ID_W-1:0]     r_wid;
    logic [ADDR_W-1:0]   r_waddr;
    logic [7:0]          r_wlen;
    logic                r_wfixed, r_wslv, r_wdec;
    logic [8:0]          r_wcnt;
    logic                w_awready, w_wready, w_bvalid;
    logic [ADDR_W-1:0]   w_wword;
    logic                w_win_range, w_wbeat_in, w_aw_hs, w_w_hs, w_aw_bad, w_ram_we;

    assign w_wword     = r_waddr >> SIZE;
    assign w_win_range = (w_wword < DEPTH_A);
    assign w_wbeat_in  = (r_wcnt <= {1'b0, r_wlen});
    assign w_aw_hs     = s_axi_awvalid && w_awready;
    assign w_w_hs      = s_axi_wvalid && w_wready;
    assign w_aw_bad    = (s_axi_awsize != SIZE_CODE) || !(s_axi_awburst == FIXED || s_axi_awburst == INCR);
    // Beats past awlen, out of range, or in a burst with bad attributes never touch memory
    assign w_ram_we    = w_w_hs && w_wbeat_in && !r_wslv && w_win_range;

    always_ff @(posedge s_aclk) begin
        if (s_areset) r_wstate <= W_IDLE;
        else          r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (s_axi_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = !w_stall;
                if (w_w_hs && s_axi_wlast) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_wcnt <= '0;
            r_wslv <= 1'b0;
            r_wdec <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wid    <= s_axi_awid;
                r_waddr  <= s_axi_awaddr;
                r_wlen   <= s_axi_awlen;
                r_wfixed <= (s_axi_awburst == FIXED);
                r_wcnt   <= '0;
                r_wslv   <= w_aw_bad;
                r_wdec   <= 1'b0;
            end
            if (w_w_hs) begin
                if (r_wcnt != 9'h1FF) r_wcnt <= r_wcnt + 9'd1;
                if (w_wbeat_in) begin
                    if (!w_win_range) r_wdec <= 1'b1;
                    if (!r_wfixed)    r_waddr <= r_waddr + BEAT_INC;
                end
                if (s_axi_wlast && r_wcnt != {1'b0, r_wlen}) r_wslv <= 1'b1;
            end
        end
    end

    assign s_axi_awready = w_awready && !s_areset;
    assign s_axi_wready  = w_wready && !s_areset;
    assign s_axi_bvalid  = w_bvalid && !s_areset;
    assign s_axi_bid     = s_axi_bvalid ? r_wid : '0;
    assign s_axi_bresp   = s_axi_bvalid ? resp_of(r_wdec, r_wslv) : OKAY;

    // ---------------- read channel ----------------
    rstate_t             r_rstate, w_rstate_nxt;
    logic [ID_W-1:0]     r_rid;
    logic [ADDR_W-1:0]   r_raddr;
    logic [7:0]          r_rlen, r_rcnt;
    logic                r_rfixed, r_rslv, r_rvalid, r_rlast;
    logic [3:0]          r_lat;
    logic [DATA_W-1:0]   r_rdata, w_ram_rdata;
    logic [1:0]          r_rresp;
    logic                w_arready, w_rload, w_ar_hs, w_r_hs, w_rin_range;
    logic [ADDR_W-1:0]   w_rword;

    assign w_rword     = r_raddr >> SIZE;
    assign w_rin_range = (w_rword < DEPTH_A);
    assign w_ar_hs     = s_axi_arvalid && w_arready;
    assign w_r_hs      = r_rvalid && s_axi_rready;

    always_ff @(posedge s_aclk) begin
        if (s_areset) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rload      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (s_axi_arvalid) w_rstate_nxt = R_WAIT;
            end
            R_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_rstate_nxt = R_DATA;
                    w_rload      = !w_stall;
                end
            end
            R_DATA: begin
                if (w_r_hs && r_rlast)                         w_rstate_nxt = R_IDLE;
                else if ((!r_rvalid || w_r_hs) && !w_stall)    w_rload = 1'b1;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Beats are registered on load so the payload cannot shift under a stalled handshake
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rcnt   <= '0;
            r_rslv   <= 1'b0;
            r_lat    <= '0;
            r_rresp  <= OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid    <= s_axi_arid;
                r_raddr  <= s_axi_araddr;
                r_rlen   <= s_axi_arlen;
                r_rfixed <= (s_axi_arburst == FIXED);
                r_rcnt   <= '0;
                r_lat    <= 4'(READ_LATENCY);
                r_rslv   <= (s_axi_arsize != SIZE_CODE) || !(s_axi_arburst == FIXED || s_axi_arburst == INCR);
            end
            if (r_rstate == R_WAIT && r_lat != 4'd0) r_lat <= r_lat - 4'd1;
            if (w_rload) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (r_rcnt == r_rlen);
                r_rcnt   <= r_rcnt + 8'd1;
                if (!r_rfixed) r_raddr <= r_raddr + BEAT_INC;
                if (!w_rin_range) begin
                    r_rresp <= DECERR;
                    r_rdata <= '0;
                end else if (r_rslv) begin
                    r_rresp <= SLVERR;
                    r_rdata <= '0;
                end else begin
                    r_rresp <= OKAY;
                    r_rdata <= w_ram_rdata;
                end
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_arready = w_arready && !s_areset;
    assign s_axi_rvalid  = r_rvalid && !s_areset;
    assign s_axi_rid     = s_axi_rvalid ? r_rid : '0;
    assign s_axi_rdata   = s_axi_rvalid ? r_rdata : '0;
    assign s_axi_rresp   = s_axi_rvalid ? r_rresp : OKAY;
    assign s_axi_rlast   = s_axi_rvalid && r_rlast;

    hbm_mem_model_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .i_clk   (s_aclk),
        .i_we    (w_ram_we),
        .i_waddr (w_wword[RAM_AW-1:0]),
        .i_wstrb (s_axi_wstrb),
        .i_wdata (s_axi_wdata),
        .i_raddr (w_rword[RAM_AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_hbm_axi_mem_model.sv
// tb/tb_hbm_axi_mem_model.sv - directed self-checking bench for hbm_axi_mem_model
module tb_hbm_axi_mem_model;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 48;
    localparam int ID_W   = 1;

    logic                s_aclk = 1'b0;
    logic                s_areset;
    logic [ID_W-1:0]     s_axi_awid;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ID_W-1:0]     s_axi_arid;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [7:0]          s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic [1:0]          s_axi_arburst;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [ID_W-1:0]     s_axi_rid;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]        wr_resp;
    logic [ID_W-1:0]   wr_bid;
    int                wr_blat;
    logic [DATA_W-1:0] rd_data [16];
    logic [1:0]        rd_resp [16];
    logic              rd_last [16];
    int                rd_lat, rd_drops, rd_n;

    always #5 s_aclk = ~s_aclk;

    hbm_axi_mem_model #(
        .DATA_W(256), .ADDR_W(48), .DEPTH(4096), .ID_W(1), .READ_LATENCY(2), .STALL_SEED(16'hACE1)
    ) dut (
        .s_aclk(s_aclk), .s_areset(s_areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic axi_write(input logic [47:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] strb, input int nbeats, input logic [255:0] base);
        int t;
        @(negedge s_aclk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = 3'd5; s_axi_awburst = burst; s_axi_awid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 50) begin @(negedge s_aclk); t++; end
        @(posedge s_aclk);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge s_aclk);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid = 1'b1; s_axi_wdata = base + 256'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == nbeats - 1);
            t = 0;
            while (!s_axi_wready && t < 50) begin @(negedge s_aclk); t++; end
            @(posedge s_aclk);
        end
        @(negedge s_aclk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        wr_blat = 0;
        while (!s_axi_bvalid && wr_blat < 50) begin @(negedge s_aclk); wr_blat++; end
        wr_resp = s_axi_bresp; wr_bid = s_axi_bid;
        s_axi_bready = 1'b1;
        @(posedge s_aclk);
        @(negedge s_aclk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [47:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input bit toggle);
        int t, k;
        bit pend, phase;
        logic [255:0] pdata;
        for (int i = 0; i < 16; i++) begin rd_data[i] = 'x; rd_resp[i] = 'x; rd_last[i] = 1'bx; end
        @(negedge s_aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = 2'b01; s_axi_arid = 1'b0;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(negedge s_aclk); t++; end
        @(posedge s_aclk);
        @(negedge s_aclk);
        s_axi_arvalid = 1'b0;
        rd_lat = 0;
        while (!s_axi_rvalid && rd_lat < 50) begin @(negedge s_aclk); rd_lat++; end
        k = 0; t = 0; pend = 1'b0; phase = 1'b1; rd_drops = 0; pdata = '0;
        while (k <= int'(len) && t < 400) begin
            s_axi_rready = toggle ? phase : 1'b1;
            phase = !phase;
            if (pend && (!s_axi_rvalid || s_axi_rdata !== pdata)) rd_drops++;
            if (s_axi_rvalid && s_axi_rready) begin
                if (k < 16) begin
                    rd_data[k] = s_axi_rdata; rd_resp[k] = s_axi_rresp; rd_last[k] = s_axi_rlast;
                end
                k++;
            end
            pend = s_axi_rvalid && !s_axi_rready;
            pdata = s_axi_rdata;
            @(negedge s_aclk);
            t++;
        end
        s_axi_rready = 1'b0;
        rd_n = k;
    endtask

    task automatic test_reset();
        s_areset = 1'b1;
        repeat (3) @(negedge s_aclk);
        n_cmp++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid});
        end
        s_areset = 1'b0;
        @(negedge s_aclk);
        n_cmp++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_basic();
        axi_write(48'h0, 8'd3, 2'b01, 32'hFFFF_FFFF, 4, 256'hA0);
        n_cmp++;
        if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: got %b expected 00", wr_resp); end
        n_cmp++;
        if (wr_blat !== 0) begin n_fail++; $display("FAIL basic_b_latency: got %0d expected 0", wr_blat); end
        n_cmp++;
        if (wr_bid !== 1'b1) begin n_fail++; $display("FAIL basic_bid: got %b expected 1", wr_bid); end
        axi_read(48'h0, 8'd3, 3'd5, 1'b0);
        n_cmp++;
        if (rd_lat !== 3) begin n_fail++; $display("FAIL basic_r_latency: got %0d expected 3", rd_lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== 256'hA0 + 256'(i) || rd_resp[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_rdata[%0d]: got %0h/%b expected %0h/00", i, rd_data[i], rd_resp[i], 256'hA0 + 256'(i));
            end
        end
        n_cmp++;
        if ({rd_last[3], rd_last[2], rd_last[1], rd_last[0]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_rlast: got %b expected 1000", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]});
        end
    endtask

    task automatic test_strobe();
        logic [255:0] exp_word;
        exp_word = {{28{8'h55}}, {4{8'hCC}}};
        axi_write(48'h20, 8'd0, 2'b01, 32'hFFFF_FFFF, 1, {32{8'h55}});
        axi_write(48'h20, 8'd0, 2'b01, 32'h0000_000F, 1, {32{8'hCC}});
        axi_read(48'h20, 8'd0, 3'd5, 1'b0);
        n_cmp++;
        if (rd_data[0] !== exp_word) begin
            n_fail++;
            $display("FAIL strobe_merge: got %0h expected %0h", rd_data[0], exp_word);
        end
    endtask

    task automatic test_decerr();
        axi_write(48'h1FFE0, 8'd0, 2'b01, 32'hFFFF_FFFF, 1, 256'hBEEF);
        axi_write(48'h20000, 8'd0, 2'b01, 32'hFFFF_FFFF, 1, 256'hDEAD);
        n_cmp++;
        if (wr_resp !== 2'b11) begin n_fail++; $display("FAIL decerr_write_bresp: got %b expected 11", wr_resp); end
        axi_read(48'h1FFE0, 8'd1, 3'd5, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 256'hBEEF || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL decerr_beat0: got %0h/%b/%b expected beef/00/0", rd_data[0], rd_resp[0], rd_last[0]);
        end
        n_cmp++;
        if (rd_data[1] !== 256'h0 || rd_resp[1] !== 2'b11 || rd_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL decerr_beat1: got %0h/%b/%b expected 0/11/1", rd_data[1], rd_resp[1], rd_last[1]);
        end
    endtask

    task automatic test_errors();
        axi_write(48'h0, 8'd3, 2'b10, 32'hFFFF_FFFF, 4, 256'h77);
        n_cmp++;
        if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL wrap_bresp: got %b expected 10", wr_resp); end
        axi_read(48'h0, 8'd0, 3'd5, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 256'hA0) begin n_fail++; $display("FAIL wrap_mem_unchanged: got %0h expected a0", rd_data[0]); end
        axi_read(48'h0, 8'd1, 3'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rd_resp[i] !== 2'b10 || rd_data[i] !== 256'h0) begin
                n_fail++;
                $display("FAIL arsize_slverr[%0d]: got %b/%0h expected 10/0", i, rd_resp[i], rd_data[i]);
            end
        end
        axi_write(48'h100, 8'd1, 2'b01, 32'hFFFF_FFFF, 2, 256'h11);
        axi_write(48'h100, 8'd0, 2'b01, 32'hFFFF_FFFF, 2, 256'h50);
        n_cmp++;
        if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL late_wlast_bresp: got %b expected 10", wr_resp); end
        axi_read(48'h100, 8'd1, 3'd5, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 256'h50 || rd_data[1] !== 256'h12) begin
            n_fail++;
            $display("FAIL extra_beat_discard: got %0h,%0h expected 50,12", rd_data[0], rd_data[1]);
        end
        axi_write(48'h200, 8'd3, 2'b01, 32'hFFFF_FFFF, 2, 256'h60);
        n_cmp++;
        if (wr_resp !== 2'b10) begin n_fail++; $display("FAIL early_wlast_bresp: got %b expected 10", wr_resp); end
    endtask

    task automatic test_concurrent();
        axi_write(48'h2000, 8'd15, 2'b01, 32'hFFFF_FFFF, 16, 256'h400);
        fork
            axi_write(48'h1000, 8'd15, 2'b01, 32'hFFFF_FFFF, 16, 256'h300);
            axi_read(48'h2000, 8'd15, 3'd5, 1'b1);
        join
        n_cmp++;
        if (wr_resp !== 2'b00) begin n_fail++; $display("FAIL conc_bresp: got %b expected 00", wr_resp); end
        n_cmp++;
        if (rd_drops !== 0) begin n_fail++; $display("FAIL conc_rvalid_drop: got %0d expected 0", rd_drops); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rd_data[i] !== 256'h400 + 256'(i)) begin
                n_fail++;
                $display("FAIL conc_rdata[%0d]: got %0h expected %0h", i, rd_data[i], 256'h400 + 256'(i));
            end
        end
        axi_read(48'h1000, 8'd15, 3'd5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rd_data[i] !== 256'h300 + 256'(i)) begin
                n_fail++;
                $display("FAIL conc_wdata[%0d]: got %0h expected %0h", i, rd_data[i], 256'h300 + 256'(i));
            end
        end
        n_cmp++;
        if (rd_last[15] !== 1'b1) begin n_fail++; $display("FAIL conc_rlast: got %b expected 1", rd_last[15]); end
    endtask

    task automatic test_reset_mid();
        int t;
        @(negedge s_aclk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 48'h2000; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd5; s_axi_arburst = 2'b01;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(negedge s_aclk); t++; end
        @(posedge s_aclk);
        @(negedge s_aclk);
        s_axi_arvalid = 1'b0;
        t = 0;
        while (!s_axi_rvalid && t < 50) begin @(negedge s_aclk); t++; end
        n_cmp++;
        if (s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL midreset_rvalid_before: got %b expected 1", s_axi_rvalid); end
        s_areset = 1'b1;
        @(negedge s_aclk);
        n_cmp++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b expected 00", {s_axi_rvalid, s_axi_arready});
        end
        s_areset = 1'b0;
        @(negedge s_aclk);
        n_cmp++;
        if ({s_axi_arready, s_axi_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_release: got %b expected 10", {s_axi_arready, s_axi_rvalid});
        end
        axi_read(48'h2000, 8'd0, 3'd5, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 256'h400 || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b1 || rd_lat !== 3) begin
            n_fail++;
            $display("FAIL midreset_new_burst: got %0h/%b/%b/%0d expected 400/00/1/3",
                     rd_data[0], rd_resp[0], rd_last[0], rd_lat);
        end
    endtask

    initial begin
        s_areset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_decerr();
        test_errors();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hbm_axi_mem_model.md
# hbm_axi_mem_model

Parametrised AXI4 slave memory model standing in for one HBM pseudo-channel in kernel-level simulation benches; a bench instantiates one per channel (Col, Val and spare ports) behind the SpMV kernels. It generalises the fixed block-RAM model with configurable data and address widths, depth, ID width and read latency. It supports concurrent independent read and write bursts, checks burst legality and returns error responses. Optional pseudo-random backpressure stresses kernel handshakes.

## Interface
- DATA_W, 256: data bus width in bits; power of two, at least 32.
- ADDR_W, 48: AXI address width.
- DEPTH, 4096: memory depth in DATA_W-bit words; power of two.
- ID_W, 1: AXI ID width.
- READ_LATENCY, 2: idle cycles between AR handshake and first R beat; 0–15.
- STALL_SEED, 16'hACE1: LFSR seed, used only with HBM_MEM_STALL_EN.

Ports:
- s_aclk in 1: clock.
- s_areset in 1: synchronous, active-high reset.
- s_axi_awid / awaddr / awlen / awsize / awburst / awvalid in ID_W / ADDR_W / 8 / 3 / 2 / 1: write address channel.
- s_axi_awready out 1: write address ready.
- s_axi_wdata / wstrb / wlast / wvalid in DATA_W / DATA_W/8 / 1 / 1: write data channel.
- s_axi_wready out 1: write data ready.
- s_axi_bid / bresp / bvalid out ID_W / 2 / 1: write response channel.
- s_axi_bready in 1: write response ready.
- s_axi_arid / araddr / arlen / arsize / arburst / arvalid in ID_W / ADDR_W / 8 / 3 / 2 / 1: read address channel.
- s_axi_arready out 1: read address ready.
- s_axi_rid / rdata / rresp / rlast / rvalid out ID_W / DATA_W / 2 / 1 / 1: read data channel.
- s_axi_rready in 1: read data ready.

## Operation
- Word index is addr >> log2(DATA_W/8).
- An address whose word index is at or above DEPTH is out of range.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, address, len and error flags, then go to W_DATA.
  - W_DATA: wready=1. Each W beat writes the bytes enabled by wstrb to the current word.
  - Beat address: INCR advances by DATA_W/8 bytes per beat; FIXED holds the address.
  - On the wlast handshake, go to W_RESP.
  - W_RESP: bvalid=1 with the latched bid. Hold until bready, then return to W_IDLE.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On AR handshake, go to R_WAIT and load the latency counter.
  - R_WAIT: go to R_DATA when the counter expires.
  - R_DATA: drive rvalid with the current word. Advance on rready.
  - rlast=1 on beat arlen. After the last handshake, return to R_IDLE.
- Error response codes:
  - SLVERR (2'b10) on bursts whose size ≠ log2(DATA_W/8).
  - SLVERR on burst type WRAP or reserved.
  - SLVERR when wlast position ≠ awlen+1 beats.
  - DECERR (2'b11) on any out-of-range beat.
- Error-beat behaviour:
  - Write beats that are errored or out of range leave memory unchanged.
  - Read beats that are errored or out of range return rdata=0.
  - Error codes are sticky per burst and reported once in bresp. Priority: DECERR over SLVERR.
  - rresp is reported per beat.
- Extra W beats after beat awlen are accepted and discarded until wlast arrives.
- Same-word read and write in the same cycle: the read returns the old data (read-before-write).
- Memory contents are not cleared by reset.

## Timing
- During reset, all outputs are 0. awready and arready rise on the first cycle after s_areset falls.
- AW-to-wready: 1 cycle. wlast handshake to bvalid: 1 cycle. bready to awready: 1 cycle.
- AR handshake to first rvalid: READ_LATENCY+1 cycles. With READ_LATENCY=0, rvalid asserts the next cycle.
- Back-to-back R beats run at one per cycle while rready=1.
- Once asserted, rvalid and bvalid, together with their payload, stay stable until the handshake.
- Read and write FSMs run fully in parallel.
- Reset mid-burst: both FSMs go to idle and the in-flight burst is dropped; no response is issued.

## Configuration
- HBM_MEM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with STALL_SEED at reset, steps every cycle.
  - When lfsr[1:0]==0, wready is forced low in W_DATA.
  - When lfsr[1:0]==0, a new R beat is not presented (rvalid stays low).
  - An already-asserted rvalid is never dropped.
- HBM_MEM_STALL_EN undefined: no LFSR, no gating; timing exactly as above.

## Structure
- Package hbm_mem_model_pkg holds:
  - resp constants: OKAY, SLVERR, DECERR;
  - burst constants: FIXED, INCR, WRAP;
  - write and read state enums;
  - LFSR tap constant.
- Sub-module hbm_mem_model_ram:
  - DEPTH × DATA_W array;
  - one byte-enable write port;
  - one combinational read port.

## Test plan
- Reset, then AW addr 0x0 len 3 INCR size 5, four W beats 0xA0..0xA3 all strobes → bresp OKAY 1 cycle after wlast. Read back addr 0x0 len 3 → 0xA0..0xA3, rlast on beat 3, first rvalid 3 cycles after AR (READ_LATENCY=2).
- Write with wstrb=32'h0000_000F over word 0x1 → only bytes 0–3 change on read-back.
- AR at word DEPTH-1, len 1 → beat 0 OKAY with data; beat 1 DECERR with rdata=0, rlast=1.
- AW with burst WRAP → bresp SLVERR, memory unchanged. AR with arsize=2 → rresp SLVERR on every beat.
- Concurrent 16-beat write and read to disjoint regions with rready toggling 1/0 → both complete, data correct, rvalid never drops before handshake.
- s_areset asserted mid read burst → rvalid 0 next cycle. After release, arready=1 and a new burst completes normally.
